// File: rtl/vote_tally_fsm.sv
// rtl/vote_tally_fsm.sv - multi-round weighted vote tallier with valid/ready ballot intake
// Saturating tally, VVIP override and a registered verdict pulse when the round closes.
module vote_tally_fsm #(
  parameter int NP_W        = 32,
  parameter int VIP_W       = 8,
  parameter int VIP_WEIGHT  = 4,
  parameter int THRESH      = 32,
  parameter int MAX_BALLOTS = 16,
  parameter int TALLY_W     = 12,
  localparam int NB_W       = $clog2(MAX_BALLOTS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NP_W-1:0]    np,
  input  logic [VIP_W-1:0]   vip,
  input  logic               vvip,
  input  logic               close,
  output logic               busy,
  output logic               res_valid,
  output logic               res,
  output logic [TALLY_W-1:0] tally,
  output logic [NB_W-1:0]    n_ballots
);

  localparam int BW = $clog2(NP_W + VIP_WEIGHT * VIP_W + 1);
  localparam int SW = ((TALLY_W > BW) ? TALLY_W : BW) + 1;
  localparam logic [SW-1:0]   TMAX     = {{(SW - TALLY_W){1'b0}}, {TALLY_W{1'b1}}};
  localparam logic [31:0]     THRESH_U = THRESH;
  localparam logic [NB_W-1:0] LAST_N   = NB_W'(MAX_BALLOTS);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  state_t state;

  logic               vvip_seen;
  logic [BW-1:0]      ballot_sum;
  logic [SW-1:0]      sum_wide;
  logic               accept;
  logic [TALLY_W-1:0] tally_next;
  logic [NB_W-1:0]    n_next;
  logic               vvip_next;
  logic               last_ballot;
  logic               pass_next;

  // Per-ballot weight is summed at full width before it meets the saturating tally.
  always_comb begin
    ballot_sum = '0;
    for (int i = 0; i < NP_W; i++)
      ballot_sum = ballot_sum + BW'(np[i]);
    for (int i = 0; i < VIP_W; i++)
      if (vip[i]) ballot_sum = ballot_sum + BW'(VIP_WEIGHT);
  end

  assign accept      = in_valid && (state == COLLECT);
  assign sum_wide    = SW'(tally) + SW'(ballot_sum);
  assign tally_next  = !accept ? tally :
                       (sum_wide > TMAX) ? {TALLY_W{1'b1}} : sum_wide[TALLY_W-1:0];
  assign n_next      = accept ? n_ballots + NB_W'(1) : n_ballots;
  assign vvip_next   = vvip_seen | (accept & vvip);
  assign last_ballot = accept && (n_next == LAST_N);
  assign pass_next   = vvip_next | ({{(32 - TALLY_W){1'b0}}, tally_next} >= THRESH_U);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tally     <= '0;
      n_ballots <= '0;
      vvip_seen <= 1'b0;
      res       <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= COLLECT;
            tally     <= '0;
            n_ballots <= '0;
            vvip_seen <= 1'b0;
            res       <= 1'b0;
            busy      <= 1'b1;
            in_ready  <= 1'b1;
          end else begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b0;
          end
        end
        COLLECT: begin
          // A restart wins over close and drops the ballot presented this cycle.
          if (start) begin
            tally     <= '0;
            n_ballots <= '0;
            vvip_seen <= 1'b0;
            res       <= 1'b0;
          end else begin
            tally     <= tally_next;
            n_ballots <= n_next;
            vvip_seen <= vvip_next;
            if (close || last_ballot) begin
              state     <= DONE;
              res       <= pass_next;
              res_valid <= 1'b1;
              busy      <= 1'b0;
              in_ready  <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vote_tally_fsm.sv
// tb/tb_vote_tally_fsm.sv - bench for vote_tally_fsm, default and 6-bit-tally instances
// Directed scenarios with literal expectations, then randomized traffic against a round model.
module tb_vote_tally_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, in_valid = 1'b0, vvip = 1'b0, close = 1'b0;
  logic [31:0] np = '0;
  logic [7:0]  vip = '0;

  logic        a_ready, a_busy, a_rv, a_res;
  logic [11:0] a_tally;
  logic [4:0]  a_n;
  logic        b_ready, b_busy, b_rv, b_res;
  logic [5:0]  b_tally;
  logic [4:0]  b_n;

  int tests = 0;
  int fails = 0;

  // Model of a round: open flag, raw counts, verdict and pulse per instance.
  bit m_on, m_rv, m_vv, m_res12, m_res6;
  int m_t12, m_t6, m_n;

  always #5 clk = ~clk;

  vote_tally_fsm u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(a_ready),
    .np(np), .vip(vip), .vvip(vvip), .close(close), .busy(a_busy), .res_valid(a_rv),
    .res(a_res), .tally(a_tally), .n_ballots(a_n)
  );

  vote_tally_fsm #(.TALLY_W(6)) u_sat (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(b_ready),
    .np(np), .vip(vip), .vvip(vvip), .close(close), .busy(b_busy), .res_valid(b_rv),
    .res(b_res), .tally(b_tally), .n_ballots(b_n)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic void model_reset();
    m_on = 0; m_rv = 0; m_vv = 0; m_res12 = 0; m_res6 = 0;
    m_t12 = 0; m_t6 = 0; m_n = 0;
  endfunction

  function automatic void model_open();
    model_reset();
    m_on = 1;
  endfunction

  function automatic void model_step();
    int add;
    m_rv = 0;
    if (start) begin
      model_open();
    end else if (m_on) begin
      if (in_valid) begin
        add   = $countones(np) + 4 * $countones(vip);
        m_t12 = sat(m_t12 + add, 4095);
        m_t6  = sat(m_t6 + add, 63);
        m_n++;
        m_vv  = m_vv | vvip;
      end
      if (close || m_n == 16) begin
        m_on    = 0;
        m_rv    = 1;
        m_res12 = m_vv || (m_t12 >= 32);
        m_res6  = m_vv || (m_t6 >= 32);
      end
    end
  endfunction

  task automatic check_all();
    chk("a_busy", a_busy, m_on);
    chk("a_in_ready", a_ready, m_on);
    chk("a_res_valid", a_rv, m_rv);
    chk("a_res", a_res, m_res12);
    chk("a_tally", a_tally, m_t12);
    chk("a_n_ballots", a_n, m_n);
    chk("b_busy", b_busy, m_on);
    chk("b_in_ready", b_ready, m_on);
    chk("b_res_valid", b_rv, m_rv);
    chk("b_res", b_res, m_res6);
    chk("b_tally", b_tally, m_t6);
    chk("b_n_ballots", b_n, m_n);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(input bit s, input bit v, input logic [31:0] n,
                        input logic [7:0] vp, input bit vv, input bit c);
    start = s; in_valid = v; np = n; vip = vp; vvip = vv; close = c;
  endtask

  task automatic idle_in();
    set_in(0, 0, 32'h0, 8'h0, 0, 0);
  endtask

  // Asserted between edges so the asynchronous clear is observable at once.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    model_reset();
    idle_in();
    @(negedge clk);
    chk("reset_tally", a_tally, 0);
    chk("reset_busy", a_busy, 0);
    chk("reset_res_valid", a_rv, 0);
    check_all();
    reset = 1'b0;

    // 1: one full normal ballot then close
    set_in(1, 0, 32'h0, 8'h0, 0, 0); cycle();
    chk("t1_busy", a_busy, 1);
    set_in(0, 1, 32'hFFFF_FFFF, 8'h0, 0, 0); cycle();
    chk("t1_tally", a_tally, 32);
    set_in(0, 0, 32'h0, 8'h0, 0, 1); cycle();
    chk("t1_res_valid", a_rv, 1);
    chk("t1_res", a_res, 1);
    idle_in(); cycle();
    chk("t1_pulse_end", a_rv, 0);
    chk("t1_res_held", a_res, 1);

    // 2: ballot and close together, 8 + 2*4 = 16
    set_in(1, 0, 32'h0, 8'h0, 0, 0); cycle();
    set_in(0, 1, 32'h0000_00FF, 8'h03, 0, 1); cycle();
    chk("t2_tally", a_tally, 16);
    chk("t2_res", a_res, 0);
    chk("t2_res_valid", a_rv, 1);

    // 3: VVIP override, also start straight out of DONE
    set_in(1, 0, 32'h0, 8'h0, 0, 0); cycle();
    chk("t3_reopen", a_busy, 1);
    set_in(0, 1, 32'h0, 8'h0, 1, 1); cycle();
    chk("t3_tally", a_tally, 0);
    chk("t3_res", a_res, 1);

    // 4: auto-close after the 16th ballot
    set_in(1, 0, 32'h0, 8'h0, 0, 0); cycle();
    for (int i = 0; i < 16; i++) begin
      set_in(0, 1, 32'h1, 8'h0, 0, 0); cycle();
      if (i == 14) chk("t4_no_early_close", a_rv, 0);
    end
    chk("t4_n_ballots", a_n, 16);
    chk("t4_tally", a_tally, 16);
    chk("t4_res_valid", a_rv, 1);
    chk("t4_res", a_res, 0);
    idle_in(); cycle();

    // 5: 6-bit tally saturates at 63
    set_in(1, 0, 32'h0, 8'h0, 0, 0); cycle();
    set_in(0, 1, 32'hFFFF_FFFF, 8'h0, 0, 0); cycle();
    set_in(0, 1, 32'hFFFF_FFFF, 8'h0, 0, 0); cycle();
    chk("t5_sat_tally", b_tally, 63);
    chk("t5_wide_tally", a_tally, 64);
    set_in(0, 0, 32'h0, 8'h0, 0, 1); cycle();
    chk("t5_sat_res", b_res, 1);

    // 6: reset mid-round, then start mid-round
    set_in(1, 0, 32'h0, 8'h0, 0, 0); cycle();
    set_in(0, 1, 32'h000F_FFFF, 8'h0, 0, 0); cycle();
    chk("t6_tally20", a_tally, 20);
    idle_in();
    pulse_reset();
    chk("t6_reset_tally", a_tally, 0);
    chk("t6_reset_ready", a_ready, 0);
    cycle();
    chk("t6_no_res_valid", a_rv, 0);
    set_in(1, 0, 32'h0, 8'h0, 0, 0); cycle();
    set_in(0, 1, 32'hFFFF_FFFF, 8'h03, 0, 0); cycle();
    chk("t6_tally40", a_tally, 40);
    set_in(1, 1, 32'hFFFF_FFFF, 8'h0, 0, 1); cycle();
    chk("t6_restart_tally", a_tally, 0);
    chk("t6_restart_rv", a_rv, 0);
    chk("t6_restart_busy", a_busy, 1);

    // zero ballots then close; close while idle
    set_in(0, 0, 32'h0, 8'h0, 0, 1); cycle();
    chk("zero_res", a_res, 0);
    chk("zero_rv", a_rv, 1);
    set_in(0, 1, 32'hFFFF_FFFF, 8'h0, 0, 1); cycle();
    set_in(0, 0, 32'h0, 8'h0, 0, 1); cycle();
    chk("idle_close_rv", a_rv, 0);
    chk("idle_close_busy", a_busy, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle_in();
        pulse_reset();
      end else begin
        start    = ($urandom_range(0, 19) == 0);
        in_valid = ($urandom_range(0, 9) < 6);
        np       = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & $urandom & $urandom);
        vip      = 8'($urandom & $urandom);
        vvip     = ($urandom_range(0, 19) == 0);
        close    = ($urandom_range(0, 9) == 0);
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
